mmul_dispatcher: RTL

MMUL_DISPATCHER -- requirements
Module: mmul_dispatcher

---
 rtl/common_pkg.sv | 28 ++
 rtl/mmul_scoreboard.sv | 70 +++++++
 rtl/mmul_dispatcher.sv | 87 ++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared types for the matrix-multiply front end.
// Instruction format, register-file addresses and dispatcher state.
package common_pkg;

    typedef logic [7:0] addr_t;

    typedef enum logic {
        MMUL_D  = 1'b0,
        MMUL_ND = 1'b1
    } op_t;

    typedef struct packed {
        op_t   op;
        addr_t dest;
        addr_t src1;
        addr_t src2;
    } instruction_t;

    localparam int MAX_INFLIGHT_DEF = 4;

    typedef logic [$clog2(MAX_INFLIGHT_DEF)-1:0] tag_t;

    typedef enum logic {
        EMPTY = 1'b0,
        PEND  = 1'b1
    } disp_state_t;

endpackage

// File: rtl/mmul_scoreboard.sv
// In-flight tracker: one valid bit and destination per tag.
// Release is registered, so a freed tag is only seen free next cycle.
module mmul_scoreboard
    import common_pkg::*;
#(
    parameter int N     = MAX_INFLIGHT_DEF,
    parameter int TAG_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc,
    input  addr_t            alloc_dest,
    input  logic             rel,
    input  logic [TAG_W-1:0] rel_tag,
    input  addr_t            chk_src1,
    input  addr_t            chk_src2,
    input  addr_t            chk_dest,
    output logic             hazard,
    output logic             full,
    output logic             any_valid,
    output logic [TAG_W-1:0] free_tag,
    output logic             rel_bad
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0] vld_q;
    addr_t        dst_q [N];
    logic [CW-1:0] cnt;
    logic          found;

    always_comb begin
        hazard   = 1'b0;
        free_tag = '0;
        found    = 1'b0;
        cnt      = '0;
        for (int i = 0; i < N; i++) begin
            if (vld_q[i]) begin
                cnt = cnt + CW'(1);
                if (dst_q[i] == chk_src1 || dst_q[i] == chk_src2 ||
                    dst_q[i] == chk_dest)
                    hazard = 1'b1;
            end else if (!found) begin
                found    = 1'b1;
                free_tag = TAG_W'(i);
            end
        end
    end

    assign full      = (cnt == CW'(N));
    assign any_valid = |vld_q;
    assign rel_bad   = rel && !vld_q[rel_tag];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int i = 0; i < N; i++)
                dst_q[i] <= '0;
        end else begin
            if (rel && vld_q[rel_tag])
                vld_q[rel_tag] <= 1'b0;
            // Allocation picks a currently-free entry, never the one being released.
            if (alloc) begin
                vld_q[free_tag] <= 1'b1;
                dst_q[free_tag] <= alloc_dest;
            end
        end
    end

endmodule

// File: rtl/mmul_dispatcher.sv
// In-order single-slot dispatcher for matrix-multiply instructions.
// Holds one pending instruction and issues it once the scoreboard clears it.
module mmul_dispatcher
    import common_pkg::*;
#(
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int TAG_W        = $clog2(MAX_INFLIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  instruction_t     in_inst,
    input  logic             in_valid,
    output logic             in_ready,
    output instruction_t     issue_inst,
    output logic [TAG_W-1:0] issue_tag,
    output logic             issue_valid,
    input  logic             issue_ready,
    input  logic             done_valid,
    input  logic [TAG_W-1:0] done_tag,
    output logic             busy,
    output logic             tag_err,
    output logic [15:0]      stall_cnt
);

    disp_state_t  state_q, state_d;
    instruction_t pend_q;
    logic         rdy_q;
    logic         hazard, full, any_valid, rel_bad;
    logic         in_fire, iss_fire;

    mmul_scoreboard #(
        .N     (MAX_INFLIGHT),
        .TAG_W (TAG_W)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .alloc      (iss_fire),
        .alloc_dest (pend_q.dest),
        .rel        (done_valid),
        .rel_tag    (done_tag),
        .chk_src1   (pend_q.src1),
        .chk_src2   (pend_q.src2),
        .chk_dest   (pend_q.dest),
        .hazard     (hazard),
        .full       (full),
        .any_valid  (any_valid),
        .free_tag   (issue_tag),
        .rel_bad    (rel_bad)
    );

    assign issue_valid = (state_q == PEND) && !hazard && !full;
    assign iss_fire    = issue_valid && issue_ready;
    // rdy_q keeps in_ready low until the first edge after reset release.
    assign in_ready    = rdy_q && ((state_q == EMPTY) || iss_fire);
    assign in_fire     = in_valid && in_ready;
    assign issue_inst  = pend_q;
    assign busy        = (state_q == PEND) || any_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (in_fire) state_d = PEND;
            PEND:    if (iss_fire && !in_fire) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            pend_q    <= '0;
            rdy_q     <= 1'b0;
            tag_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (in_fire)
                pend_q <= in_inst;
            if (rel_bad)
                tag_err <= 1'b1;
            if (state_q == PEND && !issue_valid && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
